// File: rtl/mm_pg_ctrl.sv
// mm_pg_ctrl: power-gating sequencer (OFF/WAKE/ON/IDLE) for two matching-memory units.
// Define MM_PG_AUTO_SLEEP_EN to enable the IDLE state and the auto-sleep counters.
module mm_pg_ctrl #(
    parameter int WAKE_CYC  = 4,
    parameter int SLEEP_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tok_vld,
    input  logic next_mmu1_w,
    input  logic mmu0_mm_empty,
    input  logic mmu1_mm_empty,
    input  logic mm16,
    output logic pg_mmu0,
    output logic pg_mmu1,
    output logic tok_stall
);

`ifdef MM_PG_AUTO_SLEEP_EN
    typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} state_t;
`else
    typedef enum logic [1:0] {OFF, WAKE, ON} state_t;
`endif

    localparam logic [4:0] WAKE_LD = 5'(WAKE_CYC - 1);

    state_t     state       [2];
    state_t     state_nx    [2];
    logic [4:0] wake_cnt    [2];
    logic [4:0] wake_cnt_nx [2];
    logic [1:0] req;
    logic [1:0] empty;
    logic [1:0] rdy;
    logic [1:0] pg;
    logic       tgt1;

    assign tgt1  = next_mmu1_w & ~mm16;
    assign req   = {tok_vld & tgt1, tok_vld};
    assign empty = {mmu1_mm_empty, mmu0_mm_empty};

`ifdef MM_PG_AUTO_SLEEP_EN
    localparam logic [4:0] SLEEP_LD = 5'(SLEEP_CYC - 1);

    logic [4:0] sleep_cnt    [2];
    logic [4:0] sleep_cnt_nx [2];

    assign rdy[0] = (state[0] == ON) || (state[0] == IDLE);
    assign rdy[1] = (state[1] == ON) || (state[1] == IDLE);
`else
    logic unused_empty;

    assign unused_empty = &{empty, SLEEP_CYC[0]};
    assign rdy[0]       = (state[0] == ON);
    assign rdy[1]       = (state[1] == ON);
`endif

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_nx[n[0]]    = state[n[0]];
            wake_cnt_nx[n[0]] = wake_cnt[n[0]];
`ifdef MM_PG_AUTO_SLEEP_EN
            sleep_cnt_nx[n[0]] = sleep_cnt[n[0]];
`endif
            case (state[n[0]])
                OFF: begin
                    // unit 1 may only power up behind a fully-on unit 0
                    if (req[n[0]] && (n == 0 || state[0] == ON)) begin
                        state_nx[n[0]]    = WAKE;
                        wake_cnt_nx[n[0]] = WAKE_LD;
                    end
                end
                WAKE: begin
                    if (wake_cnt[n[0]] == 5'd0) begin
                        state_nx[n[0]] = ON;
                    end else begin
                        wake_cnt_nx[n[0]] = wake_cnt[n[0]] - 5'd1;
                    end
                end
`ifdef MM_PG_AUTO_SLEEP_EN
                ON: begin
                    if (empty[n[0]] && !req[n[0]] &&
                        (n == 1 || state[1] == OFF)) begin
                        state_nx[n[0]]     = IDLE;
                        sleep_cnt_nx[n[0]] = SLEEP_LD;
                    end
                end
                IDLE: begin
                    // fresh demand wins over an expiring sleep count
                    if (req[n[0]] || !empty[n[0]]) begin
                        state_nx[n[0]] = ON;
                    end else if (sleep_cnt[n[0]] == 5'd0) begin
                        state_nx[n[0]] = OFF;
                    end else begin
                        sleep_cnt_nx[n[0]] = sleep_cnt[n[0]] - 5'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
        if (mm16 && state[1] != OFF) begin
            state_nx[1] = OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state[0]    <= OFF;
            state[1]    <= OFF;
            wake_cnt[0] <= 5'd0;
            wake_cnt[1] <= 5'd0;
            pg          <= 2'b00;
        end else begin
            state[0]    <= state_nx[0];
            state[1]    <= state_nx[1];
            wake_cnt[0] <= wake_cnt_nx[0];
            wake_cnt[1] <= wake_cnt_nx[1];
            pg          <= {state_nx[1] != OFF, state_nx[0] != OFF};
        end
    end

`ifdef MM_PG_AUTO_SLEEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sleep_cnt[0] <= 5'd0;
            sleep_cnt[1] <= 5'd0;
        end else begin
            sleep_cnt[0] <= sleep_cnt_nx[0];
            sleep_cnt[1] <= sleep_cnt_nx[1];
        end
    end
`endif

    assign pg_mmu0   = pg[0];
    assign pg_mmu1   = pg[1];
    assign tok_stall = tok_vld & (~rdy[0] | (tgt1 & ~rdy[1]));

endmodule

// File: tb/tb_mm_pg_ctrl.sv
// tb_mm_pg_ctrl: vector table, corner sequences and randomized run against a
// cycle-age reference model of the two power-gated units.
module tb_mm_pg_ctrl;

    localparam int WAKE_CYC  = 4;
    localparam int SLEEP_CYC = 16;
`ifdef MM_PG_AUTO_SLEEP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int M_OFF  = 0;
    localparam int M_WAKE = 1;
    localparam int M_ON   = 2;
    localparam int M_IDLE = 3;

    logic clk           = 1'b0;
    logic rst           = 1'b1;
    logic tok_vld       = 1'b0;
    logic next_mmu1_w   = 1'b0;
    logic mmu0_mm_empty = 1'b1;
    logic mmu1_mm_empty = 1'b1;
    logic mm16          = 1'b0;
    logic pg_mmu0;
    logic pg_mmu1;
    logic tok_stall;

    int n_cmp = 0;
    int n_bad = 0;
    int ms [2];
    int age [2];

    typedef struct packed {
        logic rst, tv, nw, e0, e1, m16, pg0, pg1, st;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    mm_pg_ctrl #(
        .WAKE_CYC (WAKE_CYC),
        .SLEEP_CYC(SLEEP_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tok_vld      (tok_vld),
        .next_mmu1_w  (next_mmu1_w),
        .mmu0_mm_empty(mmu0_mm_empty),
        .mmu1_mm_empty(mmu1_mm_empty),
        .mm16         (mm16),
        .pg_mmu0      (pg_mmu0),
        .pg_mmu1      (pg_mmu1),
        .tok_stall    (tok_stall)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input int s);
        return (s == M_ON) || (s == M_IDLE);
    endfunction

    // Reference: each unit tracks its phase and how many cycles it has aged in it.
    task automatic mcheck();
        bit t1;
        if (rst) begin
            ms[0] = M_OFF; ms[1] = M_OFF;
            age[0] = 0; age[1] = 0;
        end
        t1 = next_mmu1_w && !mm16;
        chk("pg_mmu0", int'(pg_mmu0), int'(ms[0] != M_OFF));
        chk("pg_mmu1", int'(pg_mmu1), int'(ms[1] != M_OFF));
        chk("tok_stall", int'(tok_stall),
            int'(tok_vld && (!m_rdy(ms[0]) || (t1 && !m_rdy(ms[1])))));
        chk("no_pg_01", int'({pg_mmu0, pg_mmu1} == 2'b01), 0);
    endtask

    task automatic mstep();
        int ns [2];
        int na [2];
        bit r [2];
        bit e [2];
        if (rst) return;
        r[0] = tok_vld;
        r[1] = tok_vld && next_mmu1_w && !mm16;
        e[0] = mmu0_mm_empty;
        e[1] = mmu1_mm_empty;
        for (int n = 0; n < 2; n++) begin
            ns[n] = ms[n];
            na[n] = age[n];
            case (ms[n])
                M_OFF:
                    if (r[n] && (n == 0 || ms[0] == M_ON)) begin
                        ns[n] = M_WAKE; na[n] = 0;
                    end
                M_WAKE: begin
                    na[n] = age[n] + 1;
                    if (na[n] == WAKE_CYC) ns[n] = M_ON;
                end
                M_ON:
                    if (AUTO && e[n] && !r[n] && (n == 1 || ms[1] == M_OFF)) begin
                        ns[n] = M_IDLE; na[n] = 0;
                    end
                default:
                    if (r[n] || !e[n]) ns[n] = M_ON;
                    else begin
                        na[n] = age[n] + 1;
                        if (na[n] == SLEEP_CYC) ns[n] = M_OFF;
                    end
            endcase
        end
        if (mm16 && ms[1] != M_OFF) ns[1] = M_OFF;
        ms[0] = ns[0]; ms[1] = ns[1];
        age[0] = na[0]; age[1] = na[1];
    endtask

    task automatic tick();
        @(negedge clk);
        mcheck();
        mstep();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tok_vld = 1'b0; next_mmu1_w = 1'b0;
        mmu0_mm_empty = 1'b1; mmu1_mm_empty = 1'b1; mm16 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_clear(input int lim, output int n);
        n = 0;
        #1;
        while (tok_stall && n < lim) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int lo;
        int p;
        bit seg16;
        vec_t v;

        tbl.push_back(9'b110110001);
        tbl.push_back(9'b100110000);
        tbl.push_back(9'b010010001);
        repeat (4) tbl.push_back(9'b010010101);
        tbl.push_back(9'b010010100);
        tbl.push_back(9'b011010101);
        repeat (4) tbl.push_back(9'b011010111);
        tbl.push_back(9'b011010110);
        tbl.push_back(9'b011011110);
        tbl.push_back(9'b000011100);
        tbl.push_back(9'b011011100);
        tbl.push_back(9'b011010101);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst = v.rst; tok_vld = v.tv; next_mmu1_w = v.nw;
            mmu0_mm_empty = v.e0; mmu1_mm_empty = v.e1; mm16 = v.m16;
            @(negedge clk);
            chk($sformatf("vec%0d_pg0", i), int'(pg_mmu0), int'(v.pg0));
            chk($sformatf("vec%0d_pg1", i), int'(pg_mmu1), int'(v.pg1));
            chk($sformatf("vec%0d_stall", i), int'(tok_stall), int'(v.st));
            mcheck();
            mstep();
            @(posedge clk);
            #1;
        end

        // both units from reset: unit 1 chains behind unit 0
        do_reset();
        tok_vld = 1'b1; next_mmu1_w = 1'b1; mmu0_mm_empty = 1'b0;
        wait_clear(40, n);
        chk("chain_wake_lat", n, 2 * WAKE_CYC + 2);

        // reset in the middle of a wake, then a full-length rewake
        do_reset();
        tok_vld = 1'b1; mmu0_mm_empty = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_wake_pg0", int'(pg_mmu0), 0);
        chk("rst_mid_wake_stall", int'(tok_stall), 1);
        tick();
        rst = 1'b0;
        wait_clear(40, n);
        chk("rewake_lat", n, WAKE_CYC + 1);

`ifdef MM_PG_AUTO_SLEEP_EN
        tok_vld = 1'b0; mmu0_mm_empty = 1'b1;
        n = 0;
        #1;
        while (pg_mmu0 && n < 60) begin
            tick();
            n++;
        end
        chk("sleep_lat", n, SLEEP_CYC + 1);
        tok_vld = 1'b1; mmu0_mm_empty = 1'b0;
        wait_clear(40, n);
        chk("wake_after_sleep", n, WAKE_CYC + 1);
        tok_vld = 1'b0; mmu0_mm_empty = 1'b1;
        repeat (SLEEP_CYC) tick();
        tok_vld = 1'b1;
        tick();
        chk("req_at_expiry_pg0", int'(pg_mmu0), 1);
        tok_vld = 1'b0; mmu0_mm_empty = 1'b0;
        repeat (3) tick();
        chk("req_at_expiry_hold", int'(pg_mmu0), 1);
`else
        tok_vld = 1'b0; mmu0_mm_empty = 1'b1;
        lo = 0;
        repeat (100) begin
            tick();
            if (!pg_mmu0) lo++;
        end
        chk("no_sleep_100cyc", lo, 0);
`endif

        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 3))
                0: p = 0;
                1: p = 10;
                2: p = 50;
                default: p = 90;
            endcase
            seg16 = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < 50; c++) begin
                rst           = ($urandom_range(0, 499) == 0);
                tok_vld       = ($urandom_range(0, 99) < p);
                next_mmu1_w   = $urandom_range(0, 1) == 1;
                mmu0_mm_empty = ($urandom_range(0, 99) < 75);
                mmu1_mm_empty = ($urandom_range(0, 99) < 75);
                mm16          = seg16 || ($urandom_range(0, 99) < 2);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm_pg_ctrl.md
MM_PG_CTRL -- requirements
Module: mm_pg_ctrl

Interface
REQ-001 SHALL have parameter WAKE_CYC, default 4: cycles a unit spends in WAKE before writes are allowed (range 1..31).
REQ-002 SHALL have parameter SLEEP_CYC, default 16: consecutive empty cycles a unit spends in IDLE before power-off (range 1..31).
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port tok_vld, input, 1: upstream token is presented for write or match into the matching memory this cycle.
REQ-006 SHALL have port next_mmu1_w, input, 1: manager reports that the next write targets MM unit 1; otherwise unit 0 is targeted.
REQ-007 SHALL have ports mmu0_mm_empty and mmu1_mm_empty, input, 1 each: unit holds no valid cell.
REQ-008 SHALL have port mm16, input, 1: 16-cell mode, in which only unit 0 is used.
REQ-009 SHALL have ports pg_mmu0 and pg_mmu1, output, 1 each, registered: 1 = unit powered and de-isolated.
REQ-010 SHALL have port tok_stall, output, 1, combinational: upstream shall hold its token.

Function
REQ-011 SHALL run one FSM per unit with states OFF, WAKE, ON and IDLE; pg_mmuN = 1 in WAKE, ON and IDLE, and 0 in OFF.
REQ-012 tgt1 = next_mmu1_w & ~mm16; tgt0 = ~tgt1; req0 = tok_vld | (tgt1 & tok_vld); req1 = tok_vld & tgt1.
REQ-013 OFF->WAKE when reqN = 1; the wake counter loads WAKE_CYC-1.
REQ-014 Unit 1 SHALL NOT leave OFF unless unit 0 is in ON, so {pg_mmu0,pg_mmu1} = 01 never occurs.
REQ-015 WAKE: the counter decrements each cycle; at 0 the unit goes to ON. Latency from tok_vld rising to ON is WAKE_CYC+1 cycles.
REQ-016 ON->IDLE when mmuN_mm_empty = 1 and reqN = 0; unit 0 additionally requires unit 1 to be in OFF. The sleep counter loads SLEEP_CYC-1.
REQ-017 IDLE->ON when reqN = 1 or mmuN_mm_empty = 0; this takes priority over expiry.
REQ-018 IDLE->OFF when the sleep counter is 0 and the REQ-017 condition is false; otherwise the counter decrements.
REQ-019 When mm16 = 1, unit 1 SHALL move from ON or IDLE to OFF on the next cycle and SHALL stay in OFF, regardless of its empty flag.
REQ-020 tok_stall = tok_vld & ((unit 0 not in ON and not in IDLE) | (tgt1 & unit 1 not in ON and not in IDLE)).
REQ-021 A token SHALL never be accepted (tok_vld & ~tok_stall) while its target unit is in OFF or WAKE.
REQ-022 Counters SHALL be 5 bits and SHALL never wrap below 0.
REQ-023 If reqN and the sleep counter reaching 0 occur in the same cycle, the unit SHALL stay powered (IDLE->ON).

Reset
REQ-024 While rst = 1, both FSMs SHALL be in OFF, the counters 0 and pg_mmu0 = pg_mmu1 = 0; tok_stall then equals tok_vld.
REQ-025 Reset asserted during WAKE or IDLE SHALL return the unit to OFF immediately and asynchronously, without completing the sequence.

Configuration
REQ-026 With macro MM_PG_AUTO_SLEEP_EN defined, REQ-016 to REQ-018 SHALL apply.
REQ-027 With MM_PG_AUTO_SLEEP_EN undefined, the IDLE state and sleep counters SHALL be absent; a unit in ON stays in ON until reset. Unit 1 still obeys REQ-019.

Verification
REQ-028 Reset, tok_vld = 1, tgt0 -> tok_stall = 1 for 5 cycles, pg_mmu0 = 1 from cycle 1, unit 0 in ON at cycle 5, tok_stall = 0 at cycle 5.
REQ-029 Unit 0 in ON, mmu0_mm_empty = 1, tok_vld = 0 for 17 cycles -> pg_mmu0 falls exactly 17 cycles after empty asserts; tok_vld at IDLE count 0 -> pg_mmu0 stays 1.
REQ-030 mm16 = 0, tok_vld = 1, next_mmu1_w = 1 from reset -> unit 0 ON at cycle 5, unit 1 ON at cycle 10, stall until cycle 10, 01 pattern never appears.
REQ-031 Both units ON, set mm16 = 1 -> pg_mmu1 = 0 the next cycle, pg_mmu0 unchanged; unit 0 sleeps only after pg_mmu1 = 0.
REQ-032 Assert rst at WAKE count 2 -> pg_mmu0 = 0 the same cycle; after release, a new wake takes the full WAKE_CYC.
REQ-033 Build without MM_PG_AUTO_SLEEP_EN, unit 0 ON, empty for 100 cycles -> pg_mmu0 stays 1.
